// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per cycle, on operand magnitudes. The 2*XLEN accumulator holds
// {partial product, multiplier} for multiply and {remainder, quotient}
// for divide. acc_next_o exposes the step result so the caller can latch
// the final value on the same edge as the last iteration.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   op_q;
  logic              is_div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;

  // One iteration: add-and-shift-right (mul) or shift-left-and-trial-subtract (div)
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, op_q};
    acc_d    = {mul_sum, acc_q[XLEN-1:1]};
    if (is_div_q) begin
      if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_d = {div_rem[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
    end
  end

  assign acc_next_o = acc_d;
  assign last_o     = run_i && (cnt_q == CNT_W'(XLEN-1));

  // Operand load on start, then one step per run cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      op_q     <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= {{XLEN{1'b0}}, a_i};
      op_q     <= b_i;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
    end else if (run_i) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: decode, special-case shortcut, sign handling,
// FSM sequencing the iterative core, and pipeline stall generation.
import muldiv_pkg::*;

module ex_muldiv_unit #(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        f3, f3_q;
  logic              is_mop, a_sgn, b_sgn, a_neg, b_neg;
  logic              div0, ovf, special, accept, accept_calc, accept_spec;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, fix_res, result_q;
  logic              neg_q, negr_q, last, run;
  logic [2*XLEN-1:0] acc, prod;

  assign f3     = funct_i[2:0];
  assign is_mop = (funct_i[9:3] == FUNCT7_MULDIV);
  assign a_sgn  = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  assign b_sgn  = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  assign a_neg  = a_sgn && rs1_data_i[XLEN-1];
  assign b_neg  = b_sgn && rs2_data_i[XLEN-1];
  assign a_mag  = a_neg ? (~rs1_data_i + XLEN'(1)) : rs1_data_i;
  assign b_mag  = b_neg ? (~rs2_data_i + XLEN'(1)) : rs2_data_i;

  // Divide-by-zero and INT_MIN/-1 bypass the iterative core entirely
  assign div0    = f3[2] && (rs2_data_i == '0);
  assign ovf     = ((f3 == F3_DIV) || (f3 == F3_REM)) && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
  assign special = div0 || ovf;

  // Remainder ops (f3[1]=1) return the dividend on /0 and zero on overflow
  always_comb begin
    spec_res = '1;
    if (div0)     spec_res = f3[1] ? rs1_data_i : '1;
    else if (ovf) spec_res = f3[1] ? '0 : INT_MIN;
  end

  assign accept      = (state_q == IDLE) && valid_i && is_mop && !flush_i;
  assign accept_calc = accept && !special;
  assign accept_spec = accept && special;
  assign run         = (state_q == CALC) && !flush_i;

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (accept_calc),
    .run_i      (run),
    .is_div_i   (f3[2]),
    .a_i        (a_mag),
    .b_i        (b_mag),
    .last_o     (last),
    .acc_next_o (acc)
  );

  // Sign fix-up of the final accumulator and selection of the result half
  always_comb begin
    prod    = neg_q ? (~acc + (2*XLEN)'(1)) : acc;
    fix_res = prod[XLEN-1:0];
    unique case (f3_q)
      F3_MUL:                        fix_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = neg_q ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
      default:                       fix_res = negr_q ? (~acc[2*XLEN-1:XLEN] + XLEN'(1))
                                                      : acc[2*XLEN-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and stall; DONE never re-accepts the instruction still in ID/EX
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = accept;
        if (accept_spec)      state_d = DONE;
        else if (accept_calc) state_d = CALC;
      end
      CALC: begin
        stall_o = 1'b1;
        if (flush_i)   state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operation context latched at accept; result updated only on completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f3_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept_calc) begin
        f3_q   <= f3;
        neg_q  <= a_neg ^ b_neg;
        negr_q <= a_neg;
      end
      if (accept_spec)  result_q <= spec_res;
      else if (last && run) result_q <= fix_res;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic/latency model plus directed vectors.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [9:0]  funct;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct_i(funct),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics with plain wide arithmetic
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ps;
    logic [63:0]        ua, ub, pu;
    logic signed [31:0] qa, qb, qs;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = a;
    qb = b;
    case (f3)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * $signed(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        qs = qa / qb; return qs;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        qs = qa % qb; return qs;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit model_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: cycles left in calculation, a done flag and the held result
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;
  wire         m_mop  = (funct[9:3] == 7'b0000001);

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (flush) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end else if (valid && m_mop && !flush) begin
      if (model_special(funct[2:0], rs1, rs2)) begin
        m_done <= 1'b1;
        m_res  <= model_res(funct[2:0], rs1, rs2);
      end else begin
        m_left <= 32;
        m_pend <= model_res(funct[2:0], rs1, rs2);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall",  {31'd0, stall}, {31'd0, (m_left > 0) || (!m_done && valid && m_mop && !flush)});
      chk("cyc_busy",   {31'd0, busy},  {31'd0, (m_left > 0) || m_done});
      chk("cyc_done",   {31'd0, done},  {31'd0, m_done});
      chk("cyc_result", result, m_res);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    valid = 1'b1; funct = {7'b0000001, f3}; rs1 = a; rs2 = b;
    @(negedge clk);
    chk({name, "_stall_accept"}, {31'd0, stall}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, result, exp);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk({name, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; rs1 = '0; rs2 = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);

    // flush in the middle of a DIV: no done pulse, previous result held
    @(posedge clk); #1;
    valid = 1'b1; funct = {7'b0000001, 3'd4}; rs1 = 32'hFFFFFFF9; rs2 = 32'd2;
    repeat (5) @(posedge clk);
    #1; flush = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("flush_no_done", 32'(dcnt), 32'd0);
    chk("flush_result_held", result, 32'd2);

    run_op("div_by0",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",  3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    run_op("mul_prev", 3'd0, 32'h12345678, 32'd16,       32'h23456780, 33);

    // reset at N+10 of a DIVU
    @(posedge clk); #1;
    valid = 1'b1; funct = {7'b0000001, 3'd5}; rs1 = 32'd100; rs2 = 32'd7;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall",  {31'd0, stall}, 32'd0);
    chk("rst_mid_busy",   {31'd0, busy},  32'd0);
    chk("rst_mid_done",   {31'd0, done},  32'd0);
    chk("rst_mid_result", result, 32'd0);

    // non-M instruction (ADD) is ignored
    @(posedge clk); #1;
    valid = 1'b1; funct = 10'd0; rs1 = 32'd3; rs2 = 32'd4;
    repeat (3) begin
      @(negedge clk);
      chk("add_stall", {31'd0, stall}, 32'd0);
      chk("add_busy",  {31'd0, busy},  32'd0);
    end
    @(posedge clk); #1;
    valid = 1'b0;

    // flush in IDLE suppresses accept
    @(posedge clk); #1;
    valid = 1'b1; funct = {7'b0000001, 3'd5}; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched operands and funct field; produces a 32-bit result for the EX/MEM path.
- Holds the pipeline via stall_o while an operation is in progress.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset; synchronous, active-high
valid_i  input  1  ID/EX holds a valid instruction this cycle
funct_i  input  10  {funct7, funct3} from ID/EX; M-op when funct7 == 7'b0000001
rs1_data_i  input  XLEN  operand A (already forwarded)
rs2_data_i  input  XLEN  operand B (already forwarded)
flush_i  input  1  abort any in-flight op (branch/exception flush)
stall_o  output  1  freeze PC, IF/ID and ID/EX this cycle
busy_o  output  1  state != IDLE
done_o  output  1  result_o valid this cycle (one-cycle pulse)
result_o  output  XLEN  operation result

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, counter=0, done_o=0, result_o=0, internal accumulators=0. Reset overrides flush and valid.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC: valid_i=1 and M-op and not special-case. Accept cycle = N.
  - IDLE -> DONE: valid_i=1 and M-op and special-case. Result is computed directly.
  - CALC: 32 iterations, counter 0..31; -> DONE after iteration 31.
  - DONE -> IDLE unconditionally. valid_i is ignored in DONE; the same instruction is still in ID/EX and must not be re-accepted.
- Latency:
  - Normal op: CALC in cycles N+1..N+32, DONE in N+33.
  - Special case: DONE in N+1.
- stall_o (combinational) = (IDLE and valid_i and M-op and not flush_i) or CALC or (IDLE→DONE special-case accept cycle).
  - stall_o is 0 in DONE, so the pipeline advances with result_o.
- done_o = 1 only in DONE; result_o is held stable from DONE until the next accept.
- Non-M funct (funct7 != 0000001), or valid_i=0: no action, stall_o=0, done_o=0.
- funct3 decode:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32, signed×signed.
  - 010 MULHSU: high 32, signed×unsigned.
  - 011 MULHU: high 32, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient, signed / unsigned.
  - 110 REM, 111 REMU: remainder, signed / unsigned.
- Arithmetic:
  - Operands are latched at accept and converted to magnitudes per signedness.
  - Multiply: shift-add into a 64-bit accumulator. Result is negated (two's complement, 64-bit) if the operand signs differ.
  - Divide: restoring, one quotient bit per cycle.
    - Quotient is negated if the signs differ (signed ops only).
    - Remainder takes the sign of the dividend.
- Special cases (IDLE→DONE in one cycle):
  - Divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- flush_i:
  - In CALC or DONE: next state IDLE, done_o=0 next cycle, result_o unchanged.
  - In IDLE with valid_i: no accept.
- Reset asserted mid-CALC: IDLE next cycle, and stall_o=0 from that cycle.

Decomposition:
- Package muldiv_pkg:
  - Funct7 constant FUNCT7_MULDIV.
  - funct3 encodings (F3_MUL..F3_REMU).
  - State enum (IDLE/CALC/DONE).
  - XLEN default.
- Sub-module muldiv_core holds the iterative datapath: magnitude accumulator, shift/subtract step, counter.
- ex_muldiv_unit holds the FSM, decode, special-case detection, sign fix-up and stall logic.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), valid at cycle N -> stall_o=1 for N..N+32, done_o=1 at N+33, result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF with done_o at N+1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0.
- rst_i at N+10 of a DIV -> IDLE, stall_o=0, done_o=0, result_o=0 next cycle. flush_i at N+5 -> IDLE, no done_o pulse.
- ADD (funct7=0) with valid_i=1 -> stall_o=0, busy_o=0. In DONE with valid_i still high -> return to IDLE, no second accept.
